simple_spi_slave: RTL and testbench
===================================

// Module: simple_spi_slave
// PURPOSE
//   SPI target: the responder end of the link driven by the simple_spi master.
//   Oversamples sck/ss_n/mosi on clk_i and shifts 8-bit frames in and out.
//   Byte-wide valid/ready TX and pulsed RX towards the local host logic.
//   Requires f(clk_i) >= 4 * f(sck).
// PARAMETERS
//   SYNC_STAGES  2      flip-flop stages per input synchronizer (>= 2)
//   TX_IDLE      8'hFF  byte shifted out when the TX buffer is empty at byte load
// PORTS
//   clk_i       in   1  system clock
//   rst_i       in   1  reset, synchronous, active-high
//   cpol_i      in   1  SPI clock polarity (idle level of sck)
//   cpha_i      in   1  SPI clock phase (0: sample on leading edge, 1: on trailing edge)
//   sck_i       in   1  SPI clock from master (async)
//   ss_n_i      in   1  slave select, active-low (async)
//   mosi_i      in   1  master-out data (async)
//   miso_o      out  1  slave-out data
//   miso_oe_o   out  1  miso output enable; high only while selected
//   tx_data_i   in   8  byte to transmit
//   tx_valid_i  in   1  tx_data_i valid
//   tx_ready_o  out  1  TX holding buffer empty; a write occurs on valid & ready
//   rx_data_o   out  8  last received byte; held until the next byte completes
//   rx_valid_o  out  1  one-cycle pulse when rx_data_o updates (no backpressure)
//   underrun_o  out  1  one-cycle pulse when TX_IDLE is loaded because the buffer is empty
//   busy_o      out  1  state != IDLE
// BEHAVIOUR
//   Reset (cycle after rst_i high):
//     miso_o=0, miso_oe_o=0, rx_data_o=0, rx_valid_o=0, underrun_o=0, busy_o=0.
//     TX buffer is emptied. tx_ready_o = ~buf_full & ~rst_i.
//     Reset mid-frame aborts the frame silently.
//   Inputs pass through SYNC_STAGES flops. Edges are detected on synced sck.
//     Leading edge: sck leaves cpol. Trailing edge: sck returns to cpol.
//     Sample edge = leading if cpha=0, else trailing. Drive edge = the other one.
//   cpol_i/cpha_i are latched on the ss_n falling edge; changes mid-frame are ignored.
//   FSM (package enum):
//     IDLE -> LOAD   on synced ss_n falling edge.
//     LOAD (1 cycle):
//       treg <= buffer (buffer emptied); if the buffer is empty, treg <= TX_IDLE and underrun_o pulses.
//       bcnt <= 7, miso_oe_o <= 1.
//       cpha=0: miso_o <= MSB now. cpha=1: MSB is driven on the first leading edge.
//       -> SHIFT.
//     SHIFT:
//       Sample edge: rreg <= {rreg[6:0], mosi}; bcnt decrements.
//         Sample with bcnt==0: rx_data_o <= completed byte and rx_valid_o pulses next cycle; bcnt wraps to 7.
//         The next drive edge reloads treg as in LOAD (back-to-back frames, no gap needed).
//       Drive edge: miso_o <= next treg bit.
//     Any state, synced ss_n high -> IDLE next cycle:
//       miso_oe_o=0, partial rx discarded (no rx_valid), the byte already loaded in treg is dropped.
//   The TX buffer is 1 entry.
//     A write in the same cycle as a load from an empty buffer goes to the buffer; no bypass.
//     Writes while full are impossible (tx_ready_o=0).
//   rx overwrite: a new byte replaces rx_data_o regardless of whether the host consumed the previous one.
//   Latency: miso_o changes <= SYNC_STAGES+2 clk_i cycles after the drive edge at the pin.
// CONFIGURATION
//   SPI_SLV_LSB_FIRST_EN defined:
//     bits shift LSB first on both miso and mosi.
//     rreg shifts right ({mosi, rreg[7:1]}); treg[0] is output first.
//   Undefined (default): MSB first, as described above.
// STRUCTURE
//   simple_spi_slave_pkg: state enum (IDLE, LOAD, SHIFT), TX_IDLE default constant, byte_t typedef.
//   Sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall detect, instantiated for sck, ss_n, mosi.
// TESTING
//   1. Mode 0, buffer=8'hA5, master sends 8'h3C:
//      rx_data_o=8'h3C with exactly one rx_valid_o pulse; master reads 8'hA5; tx_ready_o=1 after LOAD.
//   2. Mode 3, two back-to-back bytes 8'h12, 8'h34; host writes 8'h55 then 8'hAA during byte 1:
//      two rx pulses 12/34; master reads 55/AA; no underrun.
//   3. Buffer empty at ss_n fall:
//      master reads 8'hFF; underrun_o pulses once; rx still captured.
//   4. ss_n deasserted after 5 sample edges:
//      no rx_valid_o; busy_o=0 and miso_oe_o=0 within SYNC_STAGES+2 cycles;
//      next frame receives 8'hC3 correctly.
//   5. rst_i pulsed mid-byte:
//      all outputs at reset values next cycle; next full frame works.
//   6. SPI_SLV_LSB_FIRST_EN build, master sends 8'h01 bit0 first:
//      rx_data_o=8'h01; buffer 8'h80 appears on miso as 0..0 then 1.

Source files
------------

// File: rtl/simple_spi_slave_pkg.sv
// rtl/simple_spi_slave_pkg.sv - shared types and constants for the SPI target
// Purpose: byte type, FSM state encoding and the default idle TX byte.
// Ports: none (package).
package simple_spi_slave_pkg;

    typedef logic [7:0] byte_t;
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;

    localparam byte_t TX_IDLE_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage input synchronizer with rise/fall detect
// Purpose: brings an asynchronous pin into the clk_i domain and flags edges.
// Ports:
//   clk_i   in   system clock
//   d_i     in   asynchronous input
//   q_o     out  synchronized level
//   rise_o  out  one-cycle pulse on a synchronized 0->1 transition
//   fall_o  out  one-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
        prev_d = sync_q[STAGES-1];
    end

    // No reset on purpose: the chain must keep tracking the pin through a
    // reset, so that a reset taken while ss_n is already low does not show
    // up afterwards as a fresh falling edge (which would start a bogus frame).
    always_ff @(posedge clk_i) begin
        sync_q <= sync_d;
        prev_q <= prev_d;
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/simple_spi_slave.sv
// rtl/simple_spi_slave.sv - oversampling SPI target with 1-entry TX buffer
// Purpose: samples sck/ss_n/mosi on clk_i, shifts 8-bit frames in and out.
// Optional build macro: SPI_SLV_LSB_FIRST_EN (LSB-first shifting on miso and mosi).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cpol_i, cpha_i               SPI mode, latched at ss_n fall
//   sck_i, ss_n_i, mosi_i        asynchronous SPI pins from the master
//   miso_o, miso_oe_o            slave data out and its output enable
//   tx_data_i/valid_i/ready_o    host byte into the 1-entry TX buffer
//   rx_data_o, rx_valid_o        last received byte and its update pulse
//   underrun_o                   pulse when TX_IDLE is loaded from an empty buffer
//   busy_o                       FSM not idle
module simple_spi_slave
    import simple_spi_slave_pkg::*;
#(
    parameter int    SYNC_STAGES = 2,
    parameter byte_t TX_IDLE     = TX_IDLE_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cpol_i,
    input  logic       cpha_i,
    input  logic       sck_i,
    input  logic       ss_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       underrun_o,
    output logic       busy_o
);

`ifdef SPI_SLV_LSB_FIRST_EN
    function automatic logic out_bit(input byte_t b);
        return b[0];
    endfunction
    function automatic byte_t out_shift(input byte_t b);
        return {1'b0, b[7:1]};
    endfunction
    function automatic byte_t in_shift(input byte_t r, input logic m);
        return {m, r[7:1]};
    endfunction
`else
    function automatic logic out_bit(input byte_t b);
        return b[7];
    endfunction
    function automatic byte_t out_shift(input byte_t b);
        return {b[6:0], 1'b0};
    endfunction
    function automatic byte_t in_shift(input byte_t r, input logic m);
        return {r[6:0], m};
    endfunction
`endif

    logic sck_s, sck_rise, sck_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk_i (clk_i), .d_i (sck_i), .q_o (sck_s), .rise_o (sck_rise), .fall_o (sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clk_i (clk_i), .d_i (ss_n_i), .q_o (ss_s), .rise_o (ss_rise), .fall_o (ss_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i (clk_i), .d_i (mosi_i), .q_o (mosi_s), .rise_o (mosi_rise), .fall_o (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = sck_s ^ ss_rise ^ mosi_rise ^ mosi_fall;

    state_t     state_q, state_d;
    logic       cpol_q, cpol_d;
    logic       cpha_q, cpha_d;
    byte_t      treg_q, treg_d;
    byte_t      rreg_q, rreg_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic       reload_q, reload_d;
    logic       miso_q, miso_d;
    logic       oe_q, oe_d;
    byte_t      rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       underrun_q, underrun_d;
    byte_t      buf_q, buf_d;
    logic       buf_full_q, buf_full_d;

    logic       lead_edge, trail_edge, sample_edge, drive_edge;
    logic       do_load, buf_wr;
    byte_t      load_byte;

    assign tx_ready_o = ~buf_full_q & ~rst_i;

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        treg_d     = treg_q;
        rreg_d     = rreg_q;
        bcnt_d     = bcnt_q;
        reload_d   = reload_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        do_load    = 1'b0;

        lead_edge   = cpol_q ? sck_fall : sck_rise;
        trail_edge  = cpol_q ? sck_rise : sck_fall;
        sample_edge = cpha_q ? trail_edge : lead_edge;
        drive_edge  = cpha_q ? lead_edge : trail_edge;
        buf_wr      = tx_valid_i & tx_ready_o;
        load_byte   = buf_full_q ? buf_q : TX_IDLE;

        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d = ST_LOAD;
                    cpol_d  = cpol_i;
                    cpha_d  = cpha_i;
                end
            end
            ST_LOAD: begin
                do_load  = 1'b1;
                bcnt_d   = 3'd7;
                oe_d     = 1'b1;
                reload_d = 1'b0;
                rreg_d   = '0;
                state_d  = ST_SHIFT;
                // cpha=0 must present the first bit before the first sample
                // edge; cpha=1 waits for the first leading edge to drive it.
                if (!cpha_q) begin
                    miso_d = out_bit(load_byte);
                    treg_d = out_shift(load_byte);
                end else begin
                    treg_d = load_byte;
                end
            end
            ST_SHIFT: begin
                if (sample_edge) begin
                    rreg_d = in_shift(rreg_q, mosi_s);
                    bcnt_d = bcnt_q - 3'd1;
                    if (bcnt_q == 3'd0) begin
                        rx_data_d  = in_shift(rreg_q, mosi_s);
                        rx_valid_d = 1'b1;
                        reload_d   = 1'b1;
                    end
                end else if (drive_edge) begin
                    // First drive edge after a completed byte starts the next
                    // one, so back-to-back bytes need no gap on the wire.
                    if (reload_q) begin
                        do_load  = 1'b1;
                        reload_d = 1'b0;
                        miso_d   = out_bit(load_byte);
                        treg_d   = out_shift(load_byte);
                    end else begin
                        miso_d = out_bit(treg_q);
                        treg_d = out_shift(treg_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Deselect wins over everything: drop the partial byte and any
        // pending load so the buffer keeps its contents.
        if (state_q != ST_IDLE && ss_s) begin
            state_d    = ST_IDLE;
            oe_d       = 1'b0;
            miso_d     = 1'b0;
            reload_d   = 1'b0;
            rx_data_d  = rx_data_q;
            rx_valid_d = 1'b0;
            do_load    = 1'b0;
        end

        if (do_load) begin
            buf_full_d = 1'b0;
            underrun_d = ~buf_full_q;
        end
        // Only possible when the buffer was empty, so a write racing a load
        // lands in the buffer and the load takes TX_IDLE.
        if (buf_wr) begin
            buf_d      = tx_data_i;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            treg_q     <= '0;
            rreg_q     <= '0;
            bcnt_q     <= 3'd7;
            reload_q   <= 1'b0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            treg_q     <= treg_d;
            rreg_q     <= rreg_d;
            bcnt_q     <= bcnt_d;
            reload_q   <= reload_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end

    assign miso_o     = miso_q;
    assign miso_oe_o  = oe_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign underrun_o = underrun_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_simple_spi_slave.sv
// tb/tb_simple_spi_slave.sv - self-checking bench for simple_spi_slave
module tb_simple_spi_slave;

    localparam int H = 4;  // sck half period in clk cycles

    logic       clk = 1'b0;
    logic       rst_i, cpol_i, cpha_i, sck_i, ss_n_i, mosi_i;
    logic       miso_o, miso_oe_o, tx_valid_i, tx_ready_o;
    logic [7:0] tx_data_i, rx_data_o;
    logic       rx_valid_o, underrun_o, busy_o;

    simple_spi_slave dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .cpol_i     (cpol_i),
        .cpha_i     (cpha_i),
        .sck_i      (sck_i),
        .ss_n_i     (ss_n_i),
        .mosi_i     (mosi_i),
        .miso_o     (miso_o),
        .miso_oe_o  (miso_oe_o),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .underrun_o (underrun_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] rx_got[$];
    logic [7:0] m_tx[$];
    int         urun_cnt;
    int         exp_urun;
    int         h_wr_at[4];
    logic       hw_pend = 1'b0;
    logic [7:0] hw_byte;
    logic       mdl_full = 1'b0;
    logic [7:0] mdl_buf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_at(input logic [7:0] b, input int i);
`ifdef SPI_SLV_LSB_FIRST_EN
        return b[3'(i)];
`else
        return b[3'(7 - i)];
`endif
    endfunction

    function automatic logic [7:0] put_bit(input logic [7:0] b, input int i, input logic v);
        logic [7:0] r;
        r = b;
`ifdef SPI_SLV_LSB_FIRST_EN
        r[3'(i)] = v;
`else
        r[3'(7 - i)] = v;
`endif
        return r;
    endfunction

    // One clk cycle: observe pulses at the falling edge and serve host writes.
    task automatic tick();
        @(negedge clk);
        if (rx_valid_o) rx_got.push_back(rx_data_o);
        if (underrun_o) urun_cnt++;
        if (hw_pend && tx_ready_o) begin
            tx_data_i  = hw_byte;
            tx_valid_i = 1'b1;
            hw_pend    = 1'b0;
        end else begin
            tx_valid_i = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Reference TX buffer: a load takes the buffered byte or the idle byte.
    task automatic mdl_load(output logic [7:0] v);
        if (mdl_full) begin
            v        = mdl_buf;
            mdl_full = 1'b0;
        end else begin
            v = 8'hFF;
            exp_urun++;
        end
    endtask

    task automatic host_write(input logic [7:0] b);
        hw_byte = b;
        hw_pend = 1'b1;
        for (int k = 0; k < 20 && hw_pend; k++) tick();
        chk("host_write_accept", 32'(hw_pend), 32'd0);
        mdl_buf  = b;
        mdl_full = 1'b1;
        tick();
    endtask

    task automatic check_reset_outputs(input logic rst_now);
        chk("rst_miso", 32'(miso_o), 32'd0);
        chk("rst_oe", 32'(miso_oe_o), 32'd0);
        chk("rst_rx_data", 32'(rx_data_o), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid_o), 32'd0);
        chk("rst_underrun", 32'(underrun_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready_o), 32'(!rst_now));
    endtask

    // Master side of one select period. stop_at > 0 ends the frame after that
    // many sample edges (deselect, or a reset pulse if stop_rst).
    task automatic run_frame(input logic pol, input logic pha, input int nbytes,
                             input int stop_at, input bit stop_rst);
        logic [7:0] got, cur, v;
        logic [7:0] exp_miso[$];
        logic [7:0] exp_rx[$];
        logic [7:0] m_rx[$];
        int         samples;
        bit         stopped;
        rx_got.delete();
        urun_cnt = 0;
        exp_urun = 0;
        samples  = 0;
        stopped  = 1'b0;
        cpol_i   = pol;
        cpha_i   = pha;
        sck_i    = pol;
        ticks(4);
        ss_n_i = 1'b0;
        mdl_load(v);
        exp_miso.push_back(v);
        ticks(8);
        chk("oe_selected", 32'(miso_oe_o), 32'd1);
        chk("busy_selected", 32'(busy_o), 32'd1);
        chk("tx_ready_after_load", 32'(tx_ready_o), 32'(!mdl_full));
        for (int j = 0; j < nbytes && !stopped; j++) begin
            cur = m_tx[j];
            got = 8'h00;
            for (int i = 0; i < 8 && !stopped; i++) begin
                if (!pha) begin
                    mosi_i = bit_at(cur, i);
                    ticks(H);
                    got   = put_bit(got, i, miso_o);
                    sck_i = ~pol;
                    ticks(H);
                    sck_i = pol;
                end else begin
                    sck_i  = ~pol;
                    mosi_i = bit_at(cur, i);
                    ticks(H);
                    got   = put_bit(got, i, miso_o);
                    sck_i = pol;
                    ticks(H);
                end
                samples++;
                if (i == 3 && h_wr_at[j] >= 0) begin
                    hw_byte  = h_wr_at[j][7:0];
                    hw_pend  = 1'b1;
                    mdl_buf  = hw_byte;
                    mdl_full = 1'b1;
                end
                if (samples == stop_at) begin
                    stopped = 1'b1;
                    if (stop_rst) begin
                        rst_i = 1'b1;
                        tick();
                        check_reset_outputs(1'b1);
                        rst_i = 1'b0;
                        tick();
                        chk("tx_ready_after_rst", 32'(tx_ready_o), 32'd1);
                        mdl_full = 1'b0;
                    end
                end
            end
            if (!stopped) begin
                m_rx.push_back(got);
                exp_rx.push_back(cur);
                if (j < nbytes - 1) begin
                    mdl_load(v);
                    exp_miso.push_back(v);
                end else if (!pha) begin
                    mdl_load(v);  // final trailing edge starts a byte that is then dropped
                end
            end
        end
        ticks(H);
        ss_n_i = 1'b1;
        ticks(4);
        chk("busy_after_deselect", 32'(busy_o), 32'd0);
        chk("oe_after_deselect", 32'(miso_oe_o), 32'd0);
        ticks(2);
        chk("host_write_done", 32'(hw_pend), 32'd0);
        if (!stopped) begin
            for (int k = 0; k < m_rx.size(); k++)
                chk("miso_byte", 32'(m_rx[k]), 32'(exp_miso[k]));
        end
        chk("rx_count", 32'(rx_got.size()), 32'(exp_rx.size()));
        for (int k = 0; k < rx_got.size() && k < exp_rx.size(); k++)
            chk("rx_byte", 32'(rx_got[k]), 32'(exp_rx[k]));
        chk("underrun_count", 32'(urun_cnt), 32'(exp_urun));
        for (int k = 0; k < 4; k++) h_wr_at[k] = -1;
    endtask

    initial begin
        int mode, nb;
        rst_i      = 1'b1;
        cpol_i     = 1'b0;
        cpha_i     = 1'b0;
        sck_i      = 1'b0;
        ss_n_i     = 1'b1;
        mosi_i     = 1'b0;
        tx_data_i  = 8'h00;
        tx_valid_i = 1'b0;
        urun_cnt   = 0;
        for (int k = 0; k < 4; k++) h_wr_at[k] = -1;
        ticks(4);
        check_reset_outputs(1'b1);
        rst_i = 1'b0;
        tick();
        chk("tx_ready_idle", 32'(tx_ready_o), 32'd1);

        // Mode 0, buffered byte out, one byte in.
        host_write(8'hA5);
        m_tx = '{8'h3C};
        run_frame(1'b0, 1'b0, 1, -1, 1'b0);

        // Mode 3, two back-to-back bytes, second TX byte written mid-frame.
        host_write(8'h55);
        m_tx = '{8'h12, 8'h34};
        h_wr_at[0] = 32'h0000_00AA;
        run_frame(1'b1, 1'b1, 2, -1, 1'b0);

        // Empty buffer at select: idle byte goes out, underrun once.
        m_tx = '{8'h5A};
        run_frame(1'b1, 1'b1, 1, -1, 1'b0);

        // Deselect after five sample edges, then a clean frame.
        m_tx = '{8'hFF};
        run_frame(1'b0, 1'b0, 1, 5, 1'b0);
        host_write(8'h3E);
        m_tx = '{8'hC3};
        run_frame(1'b0, 1'b0, 1, -1, 1'b0);

        // Reset mid-byte, then a full frame.
        host_write(8'h77);
        m_tx = '{8'h96};
        run_frame(1'b0, 1'b1, 1, 3, 1'b1);
        host_write(8'h4B);
        m_tx = '{8'hE7};
        run_frame(1'b1, 1'b0, 1, -1, 1'b0);

`ifdef SPI_SLV_LSB_FIRST_EN
        host_write(8'h80);
        m_tx = '{8'h01};
        run_frame(1'b0, 1'b0, 1, -1, 1'b0);
`endif

        // Randomized frames in every mode.
        for (int f = 0; f < 8; f++) begin
            mode = int'($urandom_range(0, 3));
            nb   = int'($urandom_range(1, 3));
            if (!mdl_full && $urandom_range(0, 1) == 1)
                host_write(8'($urandom_range(0, 255)));
            m_tx.delete();
            for (int j = 0; j < nb; j++) begin
                m_tx.push_back(8'($urandom_range(0, 255)));
                if ($urandom_range(0, 1) == 1) h_wr_at[j] = int'($urandom_range(0, 255));
            end
            run_frame(mode[1], mode[0], nb, -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
